// File: rtl/line_draw_ctrl_if.sv
// -----------------------------------------------------------------------------
// line_draw_ctrl_if
// Bundles every signal between the line sequencer and its neighbours:
//   cmd_*  : line command from the front end (valid/ready)
//   dl_*   : load/step control to the DrawLine engine and its pixel output
//   px_*   : pixel write request to the framebuffer writer (valid/ready)
//   busy, line_done : sequencer status
// Modports:
//   slave  : the sequencer (line_draw_ctrl)
//   master : the environment around it (front end, DrawLine, writer)
// -----------------------------------------------------------------------------
interface line_draw_ctrl_if #(
   parameter int COLOR_W = 16
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [15:0]        cmd_x1;
   logic [15:0]        cmd_y1;
   logic [15:0]        cmd_x2;
   logic [15:0]        cmd_y2;
   logic [COLOR_W-1:0] cmd_color;

   logic               dl_calculate;
   logic [15:0]        dl_x1;
   logic [15:0]        dl_y1;
   logic [15:0]        dl_x2;
   logic [15:0]        dl_y2;
   logic               dl_get_pixel;
   logic [15:0]        dl_x_o;
   logic [15:0]        dl_y_o;

   logic               px_valid;
   logic               px_ready;
   logic [15:0]        px_x;
   logic [15:0]        px_y;
   logic [COLOR_W-1:0] px_color;

   logic               busy;
   logic               line_done;

   modport slave (
      input  cmd_valid, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color,
      output cmd_ready,
      output dl_calculate, dl_x1, dl_y1, dl_x2, dl_y2, dl_get_pixel,
      input  dl_x_o, dl_y_o,
      output px_valid, px_x, px_y, px_color,
      input  px_ready,
      output busy, line_done
   );

   modport master (
      output cmd_valid, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color,
      input  cmd_ready,
      input  dl_calculate, dl_x1, dl_y1, dl_x2, dl_y2, dl_get_pixel,
      output dl_x_o, dl_y_o,
      input  px_valid, px_x, px_y, px_color,
      output px_ready,
      input  busy, line_done
   );
endinterface

// File: rtl/line_draw_ctrl.sv
// -----------------------------------------------------------------------------
// line_draw_ctrl
// Sequencer between the line command front end and the DrawLine Bresenham
// engine. Takes one command per handshake, loads DrawLine with a one-cycle
// calculate pulse, then walks the line with get_pixel pulses, forwarding each
// on-screen pixel (plus the latched colour) to the framebuffer writer.
// DrawLine has no done flag, so the pixel count max(|dx|,|dy|)+1 is computed
// here at accept time and counted down.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (also resets DrawLine externally)
//   bus   : line_draw_ctrl_if.slave (command, DrawLine, pixel and status)
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// START  | dl_calculate pulse, DrawLine loads endpoints
// PRIME  | DrawLine presents the first pixel
// EMIT   | offer current pixel (or skip it if off-screen), advance engine
// STEP   | DrawLine settles on the next pixel
// DONE   | line_done pulse
// -----------------------------------------------------------------------------
module line_draw_ctrl #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int COLOR_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   line_draw_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_PRIME = 3'd2,
      S_EMIT  = 3'd3,
      S_STEP  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // 17-bit limits so a screen dimension of 65536 still compares correctly
   localparam logic [16:0] X_LIM = 17'(SCREEN_W);
   localparam logic [16:0] Y_LIM = 17'(SCREEN_H);

   state_t             state_q, state_d;
   logic [16:0]        remaining_q, remaining_d;
   logic [15:0]        x1_q, x1_d;
   logic [15:0]        y1_q, y1_d;
   logic [15:0]        x2_q, x2_d;
   logic [15:0]        y2_q, y2_d;
   logic [COLOR_W-1:0] color_q, color_d;

   logic signed [16:0] dx_s;
   logic signed [16:0] dy_s;
   logic [16:0]        adx;
   logic [16:0]        ady;
   logic [16:0]        span;

   logic               in_bounds;
   logic               emit_st;
   logic               advance;
   logic               more_px;

   // Endpoint span, computed in 17-bit signed so no difference can wrap
   always_comb begin
      dx_s = $signed({1'b0, bus.cmd_x2}) - $signed({1'b0, bus.cmd_x1});
      dy_s = $signed({1'b0, bus.cmd_y2}) - $signed({1'b0, bus.cmd_y1});
      adx  = dx_s[16] ? $unsigned(-dx_s) : $unsigned(dx_s);
      ady  = dy_s[16] ? $unsigned(-dy_s) : $unsigned(dy_s);
      span = (adx > ady) ? adx : ady;
   end

   always_comb begin
      in_bounds = ({1'b0, bus.dl_x_o} < X_LIM) && ({1'b0, bus.dl_y_o} < Y_LIM);
      emit_st   = (state_q == S_EMIT);
      // Off-screen pixels advance immediately; on-screen ones wait for the writer
      advance   = emit_st && (!in_bounds || bus.px_ready);
      // The last pixel of a line is never followed by a get_pixel pulse
      more_px   = (remaining_q > 17'd1);
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      x1_d        = x1_q;
      y1_d        = y1_q;
      x2_d        = x2_q;
      y2_d        = y2_q;
      color_d     = color_q;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               x1_d        = bus.cmd_x1;
               y1_d        = bus.cmd_y1;
               x2_d        = bus.cmd_x2;
               y2_d        = bus.cmd_y2;
               color_d     = bus.cmd_color;
               remaining_d = span + 17'd1;
               state_d     = S_START;
            end
         end
         S_START: state_d = S_PRIME;
         S_PRIME: state_d = S_EMIT;
         S_EMIT: begin
            if (advance) begin
               if (more_px) begin
                  remaining_d = remaining_q - 17'd1;
                  state_d     = S_STEP;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_STEP:  state_d = S_EMIT;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         x1_q        <= '0;
         y1_q        <= '0;
         x2_q        <= '0;
         y2_q        <= '0;
         color_q     <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         x1_q        <= x1_d;
         y1_q        <= y1_d;
         x2_q        <= x2_d;
         y2_q        <= y2_d;
         color_q     <= color_d;
      end
   end

   // Outputs decode the state register; px_x/px_y pass DrawLine straight
   // through, which is stable because the engine only moves on get_pixel.
   assign bus.cmd_ready    = (state_q == S_IDLE);
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.dl_calculate = (state_q == S_START);
   assign bus.dl_get_pixel = advance && more_px;
   assign bus.line_done    = (state_q == S_DONE);
   assign bus.px_valid     = emit_st && in_bounds;
   assign bus.px_x         = bus.dl_x_o;
   assign bus.px_y         = bus.dl_y_o;
   assign bus.px_color     = color_q;
   assign bus.dl_x1        = x1_q;
   assign bus.dl_y1        = y1_q;
   assign bus.dl_x2        = x2_q;
   assign bus.dl_y2        = y2_q;

endmodule

// File: tb/tb_line_draw_ctrl.sv
module tb_line_draw_ctrl;
   localparam int SW = 640;
   localparam int SH = 480;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   line_draw_ctrl_if #(.COLOR_W(CW)) bus ();

   line_draw_ctrl #(.SCREEN_W(SW), .SCREEN_H(SH), .COLOR_W(CW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One Bresenham step (environment's DrawLine algorithm)
   function automatic void bstep(input int x, input int y, input int err, input int dx,
                                 input int dy, input int sx, input int sy,
                                 output int nx, output int ny, output int nerr);
      int e2;
      e2 = 2 * err;
      nx = x; ny = y; nerr = err;
      if (e2 >= dy) begin nerr = nerr + dy; nx = x + sx; end
      if (e2 <= dx) begin nerr = nerr + dx; ny = y + sy; end
   endfunction

   // ---------------- DrawLine engine model ----------------
   int e_x, e_y, e_err, e_dx, e_dy, e_sx, e_sy;
   int t_nx, t_ny, t_ne;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_x <= 0; e_y <= 0; e_err <= 0; e_dx <= 0; e_dy <= 0; e_sx <= 0; e_sy <= 0;
      end else if (bus.dl_calculate) begin
         e_x   <= int'(bus.dl_x1);
         e_y   <= int'(bus.dl_y1);
         e_dx  <= (bus.dl_x2 > bus.dl_x1) ? int'(bus.dl_x2) - int'(bus.dl_x1) : int'(bus.dl_x1) - int'(bus.dl_x2);
         e_dy  <= -((bus.dl_y2 > bus.dl_y1) ? int'(bus.dl_y2) - int'(bus.dl_y1) : int'(bus.dl_y1) - int'(bus.dl_y2));
         e_sx  <= (bus.dl_x1 < bus.dl_x2) ? 1 : -1;
         e_sy  <= (bus.dl_y1 < bus.dl_y2) ? 1 : -1;
         e_err <= ((bus.dl_x2 > bus.dl_x1) ? int'(bus.dl_x2) - int'(bus.dl_x1) : int'(bus.dl_x1) - int'(bus.dl_x2))
                - ((bus.dl_y2 > bus.dl_y1) ? int'(bus.dl_y2) - int'(bus.dl_y1) : int'(bus.dl_y1) - int'(bus.dl_y2));
      end else if (bus.dl_get_pixel) begin
         bstep(e_x, e_y, e_err, e_dx, e_dy, e_sx, e_sy, t_nx, t_ny, t_ne);
         e_x   <= t_nx;
         e_y   <= t_ny;
         e_err <= t_ne;
      end
   end
   assign bus.dl_x_o = e_x[15:0];
   assign bus.dl_y_o = e_y[15:0];

   // ---------------- behavioural reference ----------------
   int exp_x[$], exp_y[$];
   int log_x[$], log_y[$];
   int m_n;
   logic [15:0] m_x1, m_y1, m_x2, m_y2;
   logic [CW-1:0] m_color;
   bit  active = 0;
   int  t0 = 0, rel = 0, gp_cnt = 0, stalls = 0;
   bit  prev_stall = 0;
   logic [15:0] prev_x, prev_y;
   int  last_done_rel = -1, last_gp = -1, lines_done = 0;

   // Full pixel list of a line, keeping only on-screen pixels
   function automatic void build_line(input int x1, input int y1, input int x2, input int y2);
      int adx, ady, x, y, err, sx, sy, nx, ny, ne;
      adx = (x2 > x1) ? x2 - x1 : x1 - x2;
      ady = (y2 > y1) ? y2 - y1 : y1 - y2;
      sx = (x1 < x2) ? 1 : -1;
      sy = (y1 < y2) ? 1 : -1;
      m_n = ((adx > ady) ? adx : ady) + 1;
      x = x1; y = y1; err = adx - ady;
      exp_x.delete(); exp_y.delete();
      for (int i = 0; i < m_n; i++) begin
         if (x < SW && y < SH) begin exp_x.push_back(x); exp_y.push_back(y); end
         bstep(x, y, err, adx, -ady, sx, sy, nx, ny, ne);
         x = nx; y = ny; err = ne;
      end
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         active = 0;
         prev_stall = 0;
         exp_x.delete(); exp_y.delete();
      end else begin
         rel = cyc - t0;
         chk(bus.busy == active, "busy", 64'(bus.busy), 64'(active));
         chk(bus.cmd_ready == !active, "cmd_ready", 64'(bus.cmd_ready), 64'(!active));
         chk(bus.dl_calculate == (active && rel == 1), "dl_calculate", 64'(bus.dl_calculate), 64'(active && rel == 1));
         if (active)
            chk({bus.dl_x1, bus.dl_y1, bus.dl_x2, bus.dl_y2} == {m_x1, m_y1, m_x2, m_y2}, "dl_endpoints",
                {bus.dl_x1, bus.dl_y1, bus.dl_x2, bus.dl_y2}, {m_x1, m_y1, m_x2, m_y2});
         else
            chk(!bus.px_valid && !bus.dl_get_pixel && !bus.line_done, "idle_quiet",
                {61'd0, bus.px_valid, bus.dl_get_pixel, bus.line_done}, 64'd0);
         if (prev_stall)
            chk(bus.px_valid && bus.px_x == prev_x && bus.px_y == prev_y, "px_hold",
                {15'd0, bus.px_valid, bus.px_x, bus.px_y}, {16'd1, prev_x, prev_y});
         if (bus.px_valid && active) begin
            if (exp_x.size() == 0)
               chk(1'b0, "px_extra", {bus.px_x, bus.px_y}, 64'd0);
            else
               chk(int'(bus.px_x) == exp_x[0] && int'(bus.px_y) == exp_y[0], "px_xy",
                   {bus.px_x, bus.px_y}, {exp_x[0][15:0], exp_y[0][15:0]});
            chk(bus.px_color == m_color, "px_color", 64'(bus.px_color), 64'(m_color));
         end
         if (bus.px_valid && !bus.px_ready)
            chk(!bus.dl_get_pixel, "gp_during_stall", 64'(bus.dl_get_pixel), 64'd0);
         if (active && bus.line_done) begin
            chk(rel == 4 + 2 * (m_n - 1) + stalls, "done_cycle", 64'(rel), 64'(4 + 2 * (m_n - 1) + stalls));
            chk(gp_cnt == m_n - 1, "gp_count", 64'(gp_cnt), 64'(m_n - 1));
            chk(exp_x.size() == 0, "pixels_left", 64'(exp_x.size()), 64'd0);
            last_done_rel = rel;
            last_gp = gp_cnt;
            lines_done++;
            active = 0;
         end else if (active && rel > 4 + 2 * (m_n - 1) + stalls) begin
            chk(1'b0, "done_timeout", 64'(rel), 64'(4 + 2 * (m_n - 1) + stalls));
            active = 0;
         end
         if (bus.dl_get_pixel) gp_cnt++;
         if (bus.px_valid && bus.px_ready && exp_x.size() > 0) begin
            log_x.push_back(int'(bus.px_x));
            log_y.push_back(int'(bus.px_y));
            void'(exp_x.pop_front());
            void'(exp_y.pop_front());
         end
         if (bus.px_valid && !bus.px_ready) stalls++;
         prev_stall = bus.px_valid && !bus.px_ready;
         prev_x = bus.px_x;
         prev_y = bus.px_y;
         if (bus.cmd_valid && bus.cmd_ready) begin
            t0 = cyc;
            active = 1;
            gp_cnt = 0;
            stalls = 0;
            m_x1 = bus.cmd_x1; m_y1 = bus.cmd_y1; m_x2 = bus.cmd_x2; m_y2 = bus.cmd_y2;
            m_color = bus.cmd_color;
            build_line(int'(bus.cmd_x1), int'(bus.cmd_y1), int'(bus.cmd_x2), int'(bus.cmd_y2));
         end
      end
   end

   // ---------------- stimulus ----------------
   bit rdy_mode = 0;
   always @(posedge clk) begin
      if (rdy_mode) begin
         #1;
         bus.px_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk(bus.cmd_ready == 1'b1 && bus.busy == 1'b0, {tag, "_rst_ready_busy"},
          {62'd0, bus.cmd_ready, bus.busy}, 64'd2);
      chk({bus.px_valid, bus.dl_calculate, bus.dl_get_pixel, bus.line_done} == 4'd0, {tag, "_rst_pulses"},
          64'({bus.px_valid, bus.dl_calculate, bus.dl_get_pixel, bus.line_done}), 64'd0);
      chk({bus.dl_x1, bus.dl_y1, bus.dl_x2, bus.dl_y2} == 64'd0, {tag, "_rst_endpoints"},
          {bus.dl_x1, bus.dl_y1, bus.dl_x2, bus.dl_y2}, 64'd0);
      chk(bus.px_color == '0, {tag, "_rst_color"}, 64'(bus.px_color), 64'd0);
   endtask

   task automatic send_cmd(input int x1, input int y1, input int x2, input int y2, input int color);
      log_x.delete(); log_y.delete();
      @(posedge clk); #1;
      bus.cmd_x1 = 16'(x1); bus.cmd_y1 = 16'(y1);
      bus.cmd_x2 = 16'(x2); bus.cmd_y2 = 16'(y2);
      bus.cmd_color = CW'(color);
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         if (!bus.busy) break;
         @(posedge clk); #1;
      end
      chk(!bus.busy, "line_timeout", 64'(bus.busy), 64'd0);
   endtask

   task automatic run_line(input int x1, input int y1, input int x2, input int y2, input int color);
      send_cmd(x1, y1, x2, y2, color);
      wait_idle();
   endtask

   task automatic stall_third();
      int k;
      k = 0;
      while (log_x.size() < 2 && k < 200) begin @(negedge clk); #1; k++; end
      chk(log_x.size() == 2, "stall_sync", 64'(log_x.size()), 64'd2);
      @(posedge clk); #1;
      bus.px_ready = 1'b0;
      bus.cmd_x1 = 16'd500; bus.cmd_y1 = 16'd400; bus.cmd_x2 = 16'd7; bus.cmd_y2 = 16'd9;
      bus.cmd_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk(bus.px_x == 16'd12 && bus.dl_x1 == 16'd10, "stall_hold_x12", {bus.px_x, bus.dl_x1}, {16'd12, 16'd10});
      bus.px_ready = 1'b1;
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      int done_before, x1, y1, x2, y2, k;
      bus.cmd_valid = 1'b0;
      bus.cmd_x1 = '0; bus.cmd_y1 = '0; bus.cmd_x2 = '0; bus.cmd_y2 = '0;
      bus.cmd_color = '0;
      bus.px_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("init");
      rst_n = 1'b1;

      run_line(100, 90, 50, 100, 16'hA5A5);
      chk(log_x.size() == 51, "l1_count", 64'(log_x.size()), 64'd51);
      chk(log_x[0] == 100 && log_y[0] == 90, "l1_first", 64'(log_x[0] * 65536 + log_y[0]), 64'(100 * 65536 + 90));
      chk(log_x[50] == 50 && log_y[50] == 100, "l1_last", 64'(log_x[50] * 65536 + log_y[50]), 64'(50 * 65536 + 100));
      chk(last_gp == 50, "l1_gp", 64'(last_gp), 64'd50);
      chk(last_done_rel == 104, "l1_done", 64'(last_done_rel), 64'd104);

      run_line(90, 100, 100, 50, 16'h1234);
      chk(log_x.size() == 51, "l2_count", 64'(log_x.size()), 64'd51);
      chk(log_x[50] == 100 && log_y[50] == 50, "l2_last", 64'(log_x[50] * 65536 + log_y[50]), 64'(100 * 65536 + 50));

      run_line(10, 50, 20, 50, 16'h00FF);
      chk(log_x.size() == 11, "l3_count", 64'(log_x.size()), 64'd11);
      for (int i = 0; i < 11 && i < log_x.size(); i++)
         chk(log_x[i] == 10 + i && log_y[i] == 50, "l3_seq", 64'(log_x[i] * 65536 + log_y[i]), 64'((10 + i) * 65536 + 50));

      run_line(10, 5, 10, 5, 16'hBEEF);
      chk(log_x.size() == 1 && log_x[0] == 10 && log_y[0] == 5, "l4_single",
          64'(log_x.size()), 64'd1);
      chk(last_gp == 0, "l4_gp", 64'(last_gp), 64'd0);
      chk(last_done_rel == 4, "l4_done", 64'(last_done_rel), 64'd4);

      run_line(630, 10, 650, 10, 16'h0F0F);
      chk(log_x.size() == 10, "clip_count", 64'(log_x.size()), 64'd10);
      chk(log_x[0] == 630 && log_x[9] == 639, "clip_range", 64'(log_x[0] * 65536 + log_x[9]), 64'(630 * 65536 + 639));
      chk(last_gp == 20, "clip_gp", 64'(last_gp), 64'd20);
      chk(last_done_rel == 44, "clip_done", 64'(last_done_rel), 64'd44);

      fork
         run_line(10, 50, 20, 50, 16'h7777);
         stall_third();
      join
      chk(log_x.size() == 11, "stall_count", 64'(log_x.size()), 64'd11);
      chk(last_gp == 10, "stall_gp", 64'(last_gp), 64'd10);
      chk(last_done_rel == 29, "stall_done", 64'(last_done_rel), 64'd29);

      rdy_mode = 1;
      for (int n = 0; n < 20; n++) begin
         x1 = $urandom_range(0, 700);
         y1 = $urandom_range(0, 520);
         x2 = x1 + $urandom_range(0, 60) - 30; if (x2 < 0) x2 = 0;
         y2 = y1 + $urandom_range(0, 60) - 30; if (y2 < 0) y2 = 0;
         done_before = lines_done;
         run_line(x1, y1, x2, y2, $urandom_range(0, 65535));
         chk(lines_done == done_before + 1, "rand_done", 64'(lines_done), 64'(done_before + 1));
      end
      rdy_mode = 0;
      @(posedge clk); #1;
      bus.px_ready = 1'b1;

      done_before = lines_done;
      send_cmd(100, 90, 50, 100, 16'hCAFE);
      k = 0;
      while (log_x.size() < 19 && k < 200) begin @(negedge clk); #1; k++; end
      chk(log_x.size() == 19, "rst_sync", 64'(log_x.size()), 64'd19);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk(bus.px_valid == 1'b1 && bus.px_x == 16'(log_x[18] - 1), "rst_pre_px20",
          {bus.px_valid, 15'd0, bus.px_x}, {1'b1, 15'd0, 16'(log_x[18] - 1)});
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk(lines_done == done_before, "rst_no_done", 64'(lines_done), 64'(done_before));
      run_line(10, 5, 10, 5, 16'h4321);
      chk(log_x.size() == 1 && log_x[0] == 10 && log_y[0] == 5, "post_rst_single", 64'(log_x.size()), 64'd1);
      chk(last_done_rel == 4, "post_rst_done", 64'(last_done_rel), 64'd4);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #800000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end
endmodule
